// File: rtl/irq_ctrl_n_pkg.sv
// Shared definitions for the parametrised interrupt controller: register map,
// claim-id width and the CTRL master-enable bit position.
package irq_ctrl_n_pkg;

    localparam int ID_W         = 4;
    localparam int CTRL_MEN_BIT = 8;

    typedef enum logic [2:0] {
        REG_PENDING = 3'd0,
        REG_ENABLE  = 3'd1,
        REG_MODE    = 3'd2,
        REG_PRIO    = 3'd3,
        REG_CLAIM   = 3'd4,
        REG_CTRL    = 3'd5,
        REG_FORCE   = 3'd6,
        REG_NONE    = 3'd7
    } irq_reg_e;

endpackage

// File: rtl/irq_prio_sel.sv
// Combinational eligibility filter and priority select across all sources.
// Highest priority wins; equal priorities resolve to the lowest index.
module irq_prio_sel
    import irq_ctrl_n_pkg::*;
#(
    parameter int N_SRC  = 8,
    parameter int PRIO_W = 2
) (
    input  logic [N_SRC-1:0]        pending_i,
    input  logic [N_SRC-1:0]        enable_i,
    input  logic [N_SRC*PRIO_W-1:0] prio_i,
    input  logic [PRIO_W-1:0]       threshold_i,
    input  logic                    masterEn_i,
    output logic                    any_o,
    output logic [ID_W-1:0]         id_o
);

    logic              found;
    logic [ID_W-1:0]   bestId;
    logic [PRIO_W-1:0] bestPrio;
    logic [PRIO_W-1:0] curPrio;

    // Strict greater-than on the running best keeps the earliest index on ties.
    always_comb begin
        found    = 1'b0;
        bestId   = '0;
        bestPrio = '0;
        curPrio  = '0;
        for (int i = 0; i < N_SRC; i++) begin
            curPrio = prio_i[i*PRIO_W +: PRIO_W];
            if (masterEn_i && pending_i[i] && enable_i[i] && (curPrio > threshold_i)
                && (!found || (curPrio > bestPrio))) begin
                found    = 1'b1;
                bestId   = ID_W'(i);
                bestPrio = curPrio;
            end
        end
    end

    assign any_o = found;
    assign id_o  = bestId;

endmodule

// File: rtl/irq_ctrl_n.sv
// N-source interrupt controller: pending capture, register file, single
// in-service claim/complete handshake towards the CPU trap pins.
module irq_ctrl_n
    import irq_ctrl_n_pkg::*;
#(
    parameter int N_SRC     = 8,
    parameter int PRIO_W    = 2,
    parameter int TIMER_SRC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        a,
    input  logic [31:0]       d,
    input  logic              we,
    output logic [31:0]       spo,
    input  logic [N_SRC-1:0]  irq_src,
    output logic              interrupt,
    output logic              int_istimer,
    input  logic              int_reply
);

    logic [N_SRC-1:0]        src_q, pend_q, pend_d, enable_q, mode_q;
    logic [N_SRC*PRIO_W-1:0] prio_q;
    logic [PRIO_W-1:0]       thresh_q;
    logic                    masterEn_q;
    logic                    inSvc_q, inSvc_d;
    logic [ID_W-1:0]         claimId_q, winner_q;
    logic                    irq_q, irq_d, isTimer_q, isTimer_d;

    logic [N_SRC-1:0] pending, setMask, clrMask;
    logic             anyElig, take, complete;
    logic [ID_W-1:0]  winId;
    irq_reg_e         addr;
    logic             unusedBits;

    assign addr       = irq_reg_e'(a);
    assign unusedBits = ^d;

    // Level sources expose the registered input directly; edge sources use the latch.
    assign pending = (pend_q & mode_q) | (src_q & ~mode_q);

    irq_prio_sel #(.N_SRC(N_SRC), .PRIO_W(PRIO_W)) u_sel (
        .pending_i   (pending),
        .enable_i    (enable_q),
        .prio_i      (prio_q),
        .threshold_i (thresh_q),
        .masterEn_i  (masterEn_q),
        .any_o       (anyElig),
        .id_o        (winId)
    );

    assign take     = int_reply & irq_q;
    assign complete = we && (addr == REG_CLAIM) && inSvc_q && (d[ID_W-1:0] == claimId_q);

    // Sets are OR-ed in after clears so a coincident edge/FORCE beats a W1C.
    always_comb begin
        setMask = (irq_src & ~src_q & mode_q);
        clrMask = '0;
        if (we && addr == REG_FORCE)   setMask = setMask | d[N_SRC-1:0];
        if (we && addr == REG_PENDING) clrMask = d[N_SRC-1:0];
        if (take)                      clrMask = clrMask | (N_SRC'(1) << winner_q);
        pend_d = ((pend_q & ~clrMask) | setMask) & mode_q;

        inSvc_d = inSvc_q;
        if (take)          inSvc_d = 1'b1;
        else if (complete) inSvc_d = 1'b0;

        irq_d     = masterEn_q & anyElig & ~inSvc_q & ~take;
        isTimer_d = irq_d & (winId == ID_W'(TIMER_SRC));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q      <= '0;
            pend_q     <= '0;
            enable_q   <= '0;
            mode_q     <= '0;
            prio_q     <= '0;
            thresh_q   <= '0;
            masterEn_q <= 1'b0;
            inSvc_q    <= 1'b0;
            claimId_q  <= '0;
            winner_q   <= '0;
            irq_q      <= 1'b0;
            isTimer_q  <= 1'b0;
        end else begin
            src_q     <= irq_src;
            pend_q    <= pend_d;
            inSvc_q   <= inSvc_d;
            winner_q  <= winId;
            irq_q     <= irq_d;
            isTimer_q <= isTimer_d;
            if (take) claimId_q <= winner_q;
            if (we) begin
                case (addr)
                    REG_ENABLE: enable_q <= d[N_SRC-1:0];
                    REG_MODE:   mode_q   <= d[N_SRC-1:0];
                    REG_PRIO:   prio_q   <= d[N_SRC*PRIO_W-1:0];
                    REG_CTRL: begin
                        masterEn_q <= d[CTRL_MEN_BIT];
                        thresh_q   <= d[PRIO_W-1:0];
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        spo = '0;
        case (addr)
            REG_PENDING: spo = 32'(pending);
            REG_ENABLE:  spo = 32'(enable_q);
            REG_MODE:    spo = 32'(mode_q);
            REG_PRIO:    spo = 32'(prio_q);
            REG_CLAIM:   spo = 32'({inSvc_q, claimId_q});
            REG_CTRL: begin
                spo[CTRL_MEN_BIT] = masterEn_q;
                spo[PRIO_W-1:0]   = thresh_q;
            end
            default:     spo = '0;
        endcase
    end

    assign interrupt   = irq_q;
    assign int_istimer = isTimer_q;

endmodule

// File: tb/tb_irq_ctrl_n.sv
// Directed bench for irq_ctrl_n: each task drives one scenario and checks
// hand-derived register reads and interrupt pin values inline.
module tb_irq_ctrl_n;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  a = '0;
    logic [31:0] d = '0;
    logic        we = 1'b0;
    logic [31:0] spo;
    logic [7:0]  irq_src = '0;
    logic        interrupt, int_istimer;
    logic        int_reply = 1'b0;

    int checks   = 0;
    int failures = 0;
    logic [31:0] rv;

    irq_ctrl_n #(.N_SRC(8), .PRIO_W(2), .TIMER_SRC(0)) dut (
        .clk         (clk),
        .rst         (rst),
        .a           (a),
        .d           (d),
        .we          (we),
        .spo         (spo),
        .irq_src     (irq_src),
        .interrupt   (interrupt),
        .int_istimer (int_istimer),
        .int_reply   (int_reply)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic wrReg(input logic [2:0] addr, input logic [31:0] data);
        a  = addr;
        d  = data;
        we = 1'b1;
        tick();
        we = 1'b0;
        d  = '0;
    endtask

    task automatic rdReg(input logic [2:0] addr, output logic [31:0] val);
        a = addr;
        #1;
        val = spo;
    endtask

    task automatic doReply();
        int_reply = 1'b1;
        tick();
        int_reply = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        for (int i = 0; i < 8; i++) begin
            rdReg(3'(i), rv);
            checks++;
            if (rv !== 32'h0) begin
                failures++;
                $display("[TB] FAIL reset_reg%0d got=%h exp=%h", i, rv, 32'h0);
            end
        end
        checks++;
        if (interrupt !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_irq got=%b exp=0", interrupt);
        end
        wrReg(3'd1, 32'h3);
        wrReg(3'd2, 32'h3);
        wrReg(3'd3, 32'h4);
        wrReg(3'd5, 32'h100);
        irq_src = 8'h02;
        tick();
        checks++;
        if (interrupt !== 1'b0) begin
            failures++;
            $display("[TB] FAIL first_cycle_irq got=%b exp=0", interrupt);
        end
        irq_src = 8'h00;
        tick();
        checks++;
        if (interrupt !== 1'b1 || int_istimer !== 1'b0) begin
            failures++;
            $display("[TB] FAIL latency_irq got=%b/%b exp=1/0", interrupt, int_istimer);
        end
    endtask

    task automatic test_priority();
        doReset();
        wrReg(3'd1, 32'hFF);
        wrReg(3'd2, 32'hFF);
        wrReg(3'd3, 32'hC34);
        wrReg(3'd5, 32'h100);
        irq_src = 8'h26;
        tick();
        irq_src = 8'h00;
        tick();
        checks++;
        if (interrupt !== 1'b1 || int_istimer !== 1'b0) begin
            failures++;
            $display("[TB] FAIL prio_irq got=%b/%b exp=1/0", interrupt, int_istimer);
        end
        doReply();
        rdReg(3'd4, rv);
        checks++;
        if (rv !== 32'h12 || interrupt !== 1'b0) begin
            failures++;
            $display("[TB] FAIL claim_src2 got=%h/%b exp=12/0", rv, interrupt);
        end
        rdReg(3'd0, rv);
        checks++;
        if (rv !== 32'h22) begin
            failures++;
            $display("[TB] FAIL pend_after_claim got=%h exp=22", rv);
        end
        wrReg(3'd4, 32'h5);
        tick();
        rdReg(3'd4, rv);
        checks++;
        if (rv !== 32'h12 || interrupt !== 1'b0) begin
            failures++;
            $display("[TB] FAIL wrong_complete got=%h/%b exp=12/0", rv, interrupt);
        end
        wrReg(3'd4, 32'h2);
        tick();
        checks++;
        if (interrupt !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rearb_irq got=%b exp=1", interrupt);
        end
        doReply();
        rdReg(3'd4, rv);
        checks++;
        if (rv !== 32'h15) begin
            failures++;
            $display("[TB] FAIL claim_src5 got=%h exp=15", rv);
        end
        wrReg(3'd4, 32'h5);
        tick();
        doReply();
        rdReg(3'd4, rv);
        checks++;
        if (rv !== 32'h11) begin
            failures++;
            $display("[TB] FAIL claim_src1 got=%h exp=11", rv);
        end
        wrReg(3'd4, 32'h1);
        tick();
        rdReg(3'd0, rv);
        checks++;
        if (rv !== 32'h0 || interrupt !== 1'b0) begin
            failures++;
            $display("[TB] FAIL drained got=%h/%b exp=0/0", rv, interrupt);
        end
    endtask

    task automatic test_threshold();
        doReset();
        wrReg(3'd1, 32'h08);
        wrReg(3'd2, 32'h08);
        wrReg(3'd3, 32'h80);
        wrReg(3'd5, 32'h102);
        irq_src = 8'h08;
        tick();
        irq_src = 8'h00;
        tick();
        tick();
        rdReg(3'd0, rv);
        checks++;
        if (interrupt !== 1'b0 || rv !== 32'h08) begin
            failures++;
            $display("[TB] FAIL thresh_block got=%b/%h exp=0/08", interrupt, rv);
        end
        wrReg(3'd5, 32'h101);
        tick();
        rdReg(3'd5, rv);
        checks++;
        if (interrupt !== 1'b1 || rv !== 32'h101) begin
            failures++;
            $display("[TB] FAIL thresh_pass got=%b/%h exp=1/101", interrupt, rv);
        end
    endtask

    task automatic test_level();
        doReset();
        wrReg(3'd1, 32'h10);
        wrReg(3'd2, 32'h00);
        wrReg(3'd3, 32'h100);
        wrReg(3'd5, 32'h100);
        irq_src = 8'h10;
        tick();
        tick();
        checks++;
        if (interrupt !== 1'b1) begin
            failures++;
            $display("[TB] FAIL level_irq got=%b exp=1", interrupt);
        end
        wrReg(3'd0, 32'h10);
        rdReg(3'd0, rv);
        checks++;
        if (rv !== 32'h10) begin
            failures++;
            $display("[TB] FAIL level_w1c got=%h exp=10", rv);
        end
        doReply();
        rdReg(3'd4, rv);
        checks++;
        if (rv !== 32'h14) begin
            failures++;
            $display("[TB] FAIL level_claim got=%h exp=14", rv);
        end
        wrReg(3'd4, 32'h4);
        tick();
        checks++;
        if (interrupt !== 1'b1) begin
            failures++;
            $display("[TB] FAIL level_reassert got=%b exp=1", interrupt);
        end
        doReply();
        irq_src = 8'h00;
        tick();
        wrReg(3'd4, 32'h4);
        tick();
        rdReg(3'd0, rv);
        checks++;
        if (interrupt !== 1'b0 || rv !== 32'h0) begin
            failures++;
            $display("[TB] FAIL level_dropped got=%b/%h exp=0/0", interrupt, rv);
        end
    endtask

    task automatic test_collision();
        doReset();
        wrReg(3'd2, 32'hC0);
        irq_src = 8'h40;
        a  = 3'd0;
        d  = 32'h40;
        we = 1'b1;
        tick();
        we = 1'b0;
        irq_src = 8'h00;
        rdReg(3'd0, rv);
        checks++;
        if (rv !== 32'h40) begin
            failures++;
            $display("[TB] FAIL set_beats_w1c got=%h exp=40", rv);
        end
        wrReg(3'd0, 32'h40);
        rdReg(3'd0, rv);
        checks++;
        if (rv !== 32'h0) begin
            failures++;
            $display("[TB] FAIL edge_w1c got=%h exp=0", rv);
        end
        wrReg(3'd6, 32'h80);
        rdReg(3'd0, rv);
        checks++;
        if (rv !== 32'h80) begin
            failures++;
            $display("[TB] FAIL force got=%h exp=80", rv);
        end
    endtask

    task automatic test_timer_reset();
        doReset();
        wrReg(3'd1, 32'h01);
        wrReg(3'd2, 32'h03);
        wrReg(3'd3, 32'h01);
        wrReg(3'd5, 32'h100);
        irq_src = 8'h01;
        tick();
        irq_src = 8'h00;
        tick();
        checks++;
        if (interrupt !== 1'b1 || int_istimer !== 1'b1) begin
            failures++;
            $display("[TB] FAIL timer_flag got=%b/%b exp=1/1", interrupt, int_istimer);
        end
        doReply();
        rdReg(3'd4, rv);
        checks++;
        if (rv !== 32'h10 || int_istimer !== 1'b0) begin
            failures++;
            $display("[TB] FAIL timer_claim got=%h/%b exp=10/0", rv, int_istimer);
        end
        wrReg(3'd6, 32'h02);
        rdReg(3'd0, rv);
        checks++;
        if (rv !== 32'h02) begin
            failures++;
            $display("[TB] FAIL pre_rst_pend got=%h exp=02", rv);
        end
        #1;
        rst = 1'b1;
        rdReg(3'd4, rv);
        checks++;
        if (rv !== 32'h0 || interrupt !== 1'b0) begin
            failures++;
            $display("[TB] FAIL async_claim got=%h/%b exp=0/0", rv, interrupt);
        end
        rdReg(3'd0, rv);
        checks++;
        if (rv !== 32'h0) begin
            failures++;
            $display("[TB] FAIL async_pend got=%h exp=0", rv);
        end
        rdReg(3'd1, rv);
        checks++;
        if (rv !== 32'h0) begin
            failures++;
            $display("[TB] FAIL async_enable got=%h exp=0", rv);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_priority();
        test_threshold();
        test_level();
        test_collision();
        test_timer_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
